// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - CPU fetch/data request ports and SRAM pins of sram_arbiter
interface sram_arbiter_if #(
  parameter int ADDR_W = 20
) ();
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              stall;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, stall,
           sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, stall,
           sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one async single-port SRAM between fetch and data ports
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR, DONE} state_t;

  localparam logic [2:0] WAIT_MAX = 3'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       last_grant;
  logic       gnt_d;
  logic       grant, pick_d, last_cnt;
  logic       ce_n_nxt, oe_n_nxt, we_n_nxt, if_ready_nxt, d_ready_nxt;
  logic       unused_addr_bits;

  // Ties go to the side that was not served last.
  assign grant    = bus.if_req | bus.d_req;
  assign pick_d   = bus.d_req & (~bus.if_req | ~last_grant);
  assign last_cnt = (cnt == WAIT_MAX);

  assign bus.stall = (bus.if_req & ~bus.if_ready) | (bus.d_req & ~bus.d_ready);

  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2],
                              bus.d_addr[1:0], bus.d_addr[31:ADDR_W+2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      last_grant     <= 1'b1;
      gnt_d          <= 1'b0;
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= 32'd0;
      bus.if_rdata   <= 32'd0;
      bus.d_rdata    <= 32'd0;
      bus.if_ready   <= 1'b0;
      bus.d_ready    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.sram_ce_n <= ce_n_nxt;
      bus.sram_oe_n <= oe_n_nxt;
      bus.sram_we_n <= we_n_nxt;
      bus.if_ready  <= if_ready_nxt;
      bus.d_ready   <= d_ready_nxt;
      if (state == IDLE && grant) begin
        last_grant    <= pick_d;
        gnt_d         <= pick_d;
        bus.sram_addr <= pick_d ? bus.d_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
        if (pick_d) begin
          bus.sram_wdata <= bus.d_wdata;
        end
      end
      if (state == RD && last_cnt) begin
        if (gnt_d) begin
          bus.d_rdata <= bus.sram_rdata;
        end else begin
          bus.if_rdata <= bus.sram_rdata;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = (pick_d && bus.d_we) ? WR_SETUP : RD;
          cnt_nxt   = 3'd0;
        end
      end
      RD, WR: begin
        if (last_cnt) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      WR_SETUP: state_nxt = WR;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes and ready are decoded from the next state so they register with it.
  always_comb begin
    ce_n_nxt     = 1'b1;
    oe_n_nxt     = 1'b1;
    we_n_nxt     = 1'b1;
    if_ready_nxt = 1'b0;
    d_ready_nxt  = 1'b0;
    case (state_nxt)
      RD: begin
        ce_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
      end
      WR_SETUP: ce_n_nxt = 1'b0;
      WR: begin
        ce_n_nxt = 1'b0;
        we_n_nxt = 1'b0;
      end
      DONE: begin
        if_ready_nxt = ~gnt_d;
        d_ready_nxt  = gnt_d;
      end
      default: ;
    endcase
  end
endmodule
